bank_arbiter: RTL and testbench

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arbiter_pkg.sv | 29 ++
 rtl/bank_arbiter_rr.sv | 30 +++
 rtl/bank_arbiter.sv | 127 ++++++++++++
 tb/tb_bank_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_arbiter_pkg.sv
// Shared widths, slot/tag payloads and port helpers for the four-port bank arbiter.
package bank_arbiter_pkg;

    localparam int unsigned BA_NUM_PORTS = 4;
    localparam int unsigned BA_REG_SIZE  = 8;
    localparam int unsigned BA_PORT_ID_W = 2;

    typedef logic [BA_REG_SIZE-1:0]  reg_t;
    typedef logic [BA_PORT_ID_W-1:0] port_id_t;

    // Request captured in a per-port holding slot
    typedef struct packed {
        logic we;
        reg_t addr;
        reg_t wdata;
    } slot_t;

    // Tag that follows a granted command down the response pipeline
    typedef struct packed {
        logic     valid;
        port_id_t port;
        logic     we;
    } tag_t;

    function automatic logic [BA_NUM_PORTS-1:0] port_onehot(input port_id_t id);
        port_onehot = BA_NUM_PORTS'(1) << id;
    endfunction

endpackage

// File: rtl/bank_arbiter_rr.sv
// Stateless four-way round-robin picker; search starts one past the last grant.
module rr_arbiter4
    import bank_arbiter_pkg::*;
(
    input  logic [BA_NUM_PORTS-1:0] req,
    input  port_id_t                last_gnt,
    output logic [BA_NUM_PORTS-1:0] gnt,
    output port_id_t                gnt_id
);

    port_id_t w_idx;
    logic     w_found;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // k wraps to last_gnt itself on the final probe
        for (int k = 1; k <= int'(BA_NUM_PORTS); k++) begin
            w_idx = last_gnt + port_id_t'(k);
            if (!w_found && req[w_idx]) begin
                w_found     = 1'b1;
                gnt[w_idx]  = 1'b1;
                gnt_id      = w_idx;
            end
        end
    end

endmodule

// File: rtl/bank_arbiter.sv
// Four-port single-bank arbiter: per-port holding slots, round-robin grant,
// registered bank command and a two-stage tag pipeline that returns responses.
module bank_arbiter
    import bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = BA_NUM_PORTS,
    parameter int unsigned REG_SIZE  = BA_REG_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    input  logic [NUM_PORTS-1:0]          in_we,
    input  logic [NUM_PORTS*REG_SIZE-1:0] in_addr,
    input  logic [NUM_PORTS*REG_SIZE-1:0] in_wdata,
    output logic [REG_SIZE-1:0]           bank_addr,
    output logic [REG_SIZE-1:0]           bank_wdata,
    output logic                          bank_re,
    output logic                          bank_we,
    input  logic [REG_SIZE-1:0]           bank_rdata,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic                          rsp_we,
    output logic [REG_SIZE-1:0]           rsp_data,
    output logic                          busy
);

    logic [NUM_PORTS-1:0] r_slot_full;
    slot_t                r_slot [BA_NUM_PORTS];
    port_id_t             r_last_gnt;
    logic [REG_SIZE-1:0]  r_bank_addr;
    logic [REG_SIZE-1:0]  r_bank_wdata;
    logic                 r_bank_re;
    logic                 r_bank_we;
    tag_t                 r_s1;
    tag_t                 r_s2;

    logic [NUM_PORTS-1:0] w_gnt;
    port_id_t             w_gnt_id;
    logic                 w_any;
    slot_t                w_winner;

    rr_arbiter4 u_rr (
        .req      (r_slot_full),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt),
        .gnt_id   (w_gnt_id)
    );

    assign w_any    = |r_slot_full;
    assign w_winner = r_slot[w_gnt_id];

    // Slot load/clear; a granted slot is full, so it never collides with a load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot_full <= '0;
            for (int i = 0; i < int'(BA_NUM_PORTS); i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(BA_NUM_PORTS); i++) begin
                if (w_gnt[i]) begin
                    r_slot_full[i] <= 1'b0;
                end else if (in_valid[i] && !r_slot_full[i]) begin
                    r_slot_full[i]    <= 1'b1;
                    r_slot[i].we      <= in_we[i];
                    r_slot[i].addr    <= in_addr[i*REG_SIZE +: REG_SIZE];
                    r_slot[i].wdata   <= in_wdata[i*REG_SIZE +: REG_SIZE];
                end
            end
        end
    end

    // Bank command issue; address/data hold when nothing is granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_bank_re    <= 1'b0;
            r_bank_we    <= 1'b0;
            r_last_gnt   <= port_id_t'(BA_NUM_PORTS - 1);
        end else if (w_any) begin
            r_bank_addr  <= w_winner.addr;
            r_bank_wdata <= w_winner.wdata;
            r_bank_re    <= ~w_winner.we;
            r_bank_we    <= w_winner.we;
            r_last_gnt   <= w_gnt_id;
        end else begin
            r_bank_re    <= 1'b0;
            r_bank_we    <= 1'b0;
        end
    end

    // Response tag pipeline: stage 1 aligns with the command, stage 2 with bank data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1.valid <= w_any;
            r_s1.port  <= w_gnt_id;
            r_s1.we    <= w_winner.we;
            r_s2       <= r_s1;
        end
    end

    // Bank read data arrives in the response cycle, so the response is decoded from stage 2
    always_comb begin
        rsp_valid = '0;
        rsp_we    = 1'b0;
        rsp_data  = '0;
        if (r_s2.valid) begin
            rsp_valid = port_onehot(r_s2.port);
            rsp_we    = r_s2.we;
            if (!r_s2.we) begin
                rsp_data = bank_rdata;
            end
        end
    end

    assign in_ready   = ~r_slot_full;
    assign busy       = w_any | r_s1.valid | r_s2.valid;
    assign bank_addr  = r_bank_addr;
    assign bank_wdata = r_bank_wdata;
    assign bank_re    = r_bank_re;
    assign bank_we    = r_bank_we;

endmodule

// File: tb/tb_bank_arbiter.sv
// Self-checking bench for bank_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural bank memory.
module tb_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid, in_ready, in_we;
    logic [31:0] in_addr, in_wdata;
    logic [7:0]  bank_addr, bank_wdata, bank_rdata;
    logic        bank_re, bank_we;
    logic [3:0]  rsp_valid;
    logic        rsp_we;
    logic [7:0]  rsp_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bank_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_we      (in_we),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_re    (bank_re),
        .bank_we    (bank_we),
        .bank_rdata (bank_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_we     (rsp_we),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    // Behavioural synchronous bank: one-cycle read latency
    logic [7:0] bmem [256];
    initial bank_rdata = 8'h00;
    always @(posedge clk) begin
        if (bank_re) bank_rdata <= bmem[bank_addr];
        if (bank_we) bmem[bank_addr] = bank_wdata;
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    bit         m_full [4];
    bit         m_we   [4];
    logic [7:0] m_addr [4];
    logic [7:0] m_wd   [4];
    int         m_last;
    bit         m_bre, m_bwe;
    logic [7:0] m_baddr, m_bwdata;
    bit         m_s1v, m_s1we, m_s2v, m_s2we;
    int         m_s1p, m_s2p;
    logic [7:0] m_s2data;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_wd[i] = 0;
        end
        m_last = 3;
        m_bre = 0; m_bwe = 0; m_baddr = 0; m_bwdata = 0;
        m_s1v = 0; m_s1we = 0; m_s1p = 0;
        m_s2v = 0; m_s2we = 0; m_s2p = 0; m_s2data = 0;
    endtask

    // One clock of the transaction model, given the inputs presented this cycle
    task automatic model_advance(input logic [3:0] v, input logic [3:0] we,
                                 input logic [31:0] a, input logic [31:0] d);
        int w;
        logic [7:0] rd;
        rd = 8'h00;
        if (m_bwe) ref_mem[m_baddr] = m_bwdata;
        if (m_bre) rd = ref_mem[m_baddr];
        m_s2v = m_s1v; m_s2p = m_s1p; m_s2we = m_s1we; m_s2data = rd;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            if (w < 0 && m_full[(m_last + k) % 4]) w = (m_last + k) % 4;
        end
        if (w >= 0) begin
            m_bre = !m_we[w]; m_bwe = m_we[w];
            m_baddr = m_addr[w]; m_bwdata = m_wd[w];
            m_last = w;
            m_s1v = 1; m_s1p = w; m_s1we = m_we[w];
        end else begin
            m_bre = 0; m_bwe = 0; m_s1v = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i] && !m_full[i]) begin
                m_full[i] = 1; m_we[i] = we[i];
                m_addr[i] = a[i*8 +: 8]; m_wd[i] = d[i*8 +: 8];
            end
        end
        if (w >= 0) m_full[w] = 0;
    endtask

    // Called just after a negedge; returns just after the following negedge
    task automatic step(input logic [3:0] v, input logic [3:0] we,
                        input logic [31:0] a, input logic [31:0] d);
        in_valid = v; in_we = we; in_addr = a; in_wdata = d;
        model_advance(v, we, a, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(4'h0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        in_valid = 0; in_we = 0; in_addr = 0; in_wdata = 0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_we = 0; in_addr = 0; in_wdata = 0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bank_re, bank_we} !== 2'b00) begin
            n_fail++; $display("FAIL reset_bank_en: got %b expected 00", {bank_re, bank_we});
        end
        n_tests++;
        if ({bank_addr, bank_wdata} !== 16'h0) begin
            n_fail++; $display("FAIL reset_bank_bus: got %h expected 0000", {bank_addr, bank_wdata});
        end
        n_tests++;
        if ({rsp_valid, rsp_we, rsp_data} !== 13'h0) begin
            n_fail++; $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_we, rsp_data});
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        reset = 1'b1;
        idle();
        n_tests++;
        if (in_ready !== 4'hF) begin
            n_fail++; $display("FAIL reset_ready: got %h expected f", in_ready);
        end
    endtask

    task automatic test_single_read();
        bmem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        step(4'b0010, 4'b0000, 32'h0000_1000, 32'h0);
        idle();
        n_tests++;
        if ({bank_re, bank_we, bank_addr} !== {2'b10, 8'h10}) begin
            n_fail++; $display("FAIL single_read_cmd: got re/we/addr %b%b/%h expected 10/10",
                               bank_re, bank_we, bank_addr);
        end
        idle();
        n_tests++;
        if ({rsp_valid, rsp_we, rsp_data} !== {4'b0010, 1'b0, 8'hA5}) begin
            n_fail++; $display("FAIL single_read_rsp: got %b/%b/%h expected 0010/0/a5",
                               rsp_valid, rsp_we, rsp_data);
        end
        idle();
        n_tests++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_read_pulse: got %b expected 0000", rsp_valid);
        end
    endtask

    task automatic test_write_read();
        step(4'b0001, 4'b0001, 32'h0000_0005, 32'h0000_003C);
        idle();
        step(4'b0001, 4'b0000, 32'h0000_0005, 32'h0);
        n_tests++;
        if ({rsp_valid, rsp_we, rsp_data} !== {4'b0001, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL write_rsp: got %b/%b/%h expected 0001/1/00",
                               rsp_valid, rsp_we, rsp_data);
        end
        idle();
        idle();
        n_tests++;
        if ({rsp_valid, rsp_we, rsp_data} !== {4'b0001, 1'b0, 8'h3C}) begin
            n_fail++; $display("FAIL read_after_write: got %b/%b/%h expected 0001/0/3c",
                               rsp_valid, rsp_we, rsp_data);
        end
    endtask

    task automatic test_all_ports();
        logic [31:0] a;
        logic [3:0]  exp_v;
        a = 32'h44_33_22_11;
        do_reset();
        step(4'hF, 4'h0, a, 32'h0);
        for (int s = 1; s <= 6; s++) begin
            idle();
            if (s <= 4) begin
                n_tests++;
                if (bank_addr !== a[(s-1)*8 +: 8] || bank_re !== 1'b1) begin
                    n_fail++; $display("FAIL all_ports_grant%0d: got addr %h re %b expected %h 1",
                                       s, bank_addr, bank_re, a[(s-1)*8 +: 8]);
                end
            end
            exp_v = (s >= 2 && s <= 5) ? 4'(1 << (s - 2)) : 4'b0000;
            n_tests++;
            if (rsp_valid !== exp_v) begin
                n_fail++; $display("FAIL all_ports_rsp%0d: got %b expected %b", s, rsp_valid, exp_v);
            end
        end
    endtask

    task automatic test_stream();
        logic [3:0] v;
        bit         r2 [9];
        bit         p0_pending, p0_seen;
        int         wait_cnt;
        p0_pending = 0; p0_seen = 0; wait_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            r2[c] = in_ready[2];
            if (p0_pending && bank_addr === 8'h77 && bank_re === 1'b1) p0_seen = 1;
            if (p0_pending && !p0_seen) wait_cnt++;
            v = 4'b0100;
            if (c == 1) begin
                v[0] = 1'b1;
                p0_pending = in_ready[0];
            end
            step(v, 4'b0000, 32'h00_22_00_77, 32'h0);
        end
        n_tests++;
        if (!p0_seen || wait_cnt > 2) begin
            n_fail++; $display("FAIL stream_port0_grant: got seen=%0d wait=%0d expected seen=1 wait<=2",
                               p0_seen, wait_cnt);
        end
        for (int c = 1; c < 9; c++) begin
            n_tests++;
            if (r2[c] == r2[c-1]) begin
                n_fail++; $display("FAIL stream_ready_toggle%0d: got %0d expected %0d", c, r2[c], !r2[c-1]);
            end
        end
        for (int c = 0; c < 4; c++) idle();
    endtask

    task automatic test_idle();
        logic [7:0] saved;
        int         exp_w;
        for (int c = 0; c < 4; c++) idle();
        saved = bank_addr;
        exp_w = (m_last + 1) % 4;
        for (int c = 0; c < 10; c++) begin
            idle();
            n_tests++;
            if (bank_re !== 1'b0 || bank_we !== 1'b0 || bank_addr !== saved || busy !== 1'b0) begin
                n_fail++; $display("FAIL idle%0d: got re %b we %b addr %h busy %b expected 0 0 %h 0",
                                   c, bank_re, bank_we, bank_addr, busy, saved);
            end
        end
        step(4'hF, 4'h0, 32'h43_42_41_40, 32'h0);
        idle();
        n_tests++;
        if (bank_addr !== 8'(8'h40 + exp_w)) begin
            n_fail++; $display("FAIL idle_last_gnt: got addr %h expected %h", bank_addr, 8'(8'h40 + exp_w));
        end
        for (int c = 0; c < 6; c++) idle();
    endtask

    task automatic test_reset_mid();
        step(4'b1011, 4'b0000, 32'h30_00_31_32, 32'h0);
        idle();
        reset = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({bank_re, bank_we, bank_addr, bank_wdata} !== 18'h0 ||
            {rsp_valid, rsp_we, rsp_data} !== 13'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got re%b we%b a%h d%h v%b busy%b expected all 0",
                               bank_re, bank_we, bank_addr, bank_wdata, rsp_valid, busy);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            n_tests++;
            if (rsp_valid !== 4'b0000 || in_ready !== 4'hF) begin
                n_fail++; $display("FAIL reset_mid_after%0d: got rsp %b ready %h expected 0000 f",
                                   c, rsp_valid, in_ready);
            end
            idle();
        end
    endtask

    task automatic test_random();
        logic [3:0]  v, we, er, ev;
        logic [31:0] a, d;
        logic [7:0]  ed;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) er[i] = !m_full[i];
            ev = m_s2v ? 4'(1 << m_s2p) : 4'b0000;
            ed = (m_s2v && !m_s2we) ? m_s2data : 8'h00;
            n_tests++;
            if (in_ready !== er) begin
                n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, in_ready, er);
            end
            n_tests++;
            if ({bank_re, bank_we, bank_addr, bank_wdata} !== {m_bre, m_bwe, m_baddr, m_bwdata}) begin
                n_fail++; $display("FAIL rnd_bank c%0d: got %b%b %h %h expected %b%b %h %h", c,
                                   bank_re, bank_we, bank_addr, bank_wdata, m_bre, m_bwe, m_baddr, m_bwdata);
            end
            n_tests++;
            if ({rsp_valid, rsp_we, rsp_data} !== {ev, m_s2v & m_s2we, ed}) begin
                n_fail++; $display("FAIL rnd_rsp c%0d: got %b/%b/%h expected %b/%b/%h", c,
                                   rsp_valid, rsp_we, rsp_data, ev, m_s2v & m_s2we, ed);
            end
            n_tests++;
            if (busy !== (m_full[0] | m_full[1] | m_full[2] | m_full[3] | m_s1v | m_s2v)) begin
                n_fail++; $display("FAIL rnd_busy c%0d: got %b", c, busy);
            end
            v  = 4'($urandom);
            we = 4'($urandom);
            for (int i = 0; i < 4; i++) a[i*8 +: 8] = 8'($urandom_range(0, 15));
            d  = $urandom;
            step(v, we, a, d);
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 0; in_we = 0; in_addr = 0; in_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            bmem[i]    = 8'($urandom);
            ref_mem[i] = bmem[i];
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_write_read();
        test_all_ports();
        test_stream();
        test_idle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
